// File: rtl/bp_be_pkg.sv
// bp_be_pkg: shared types for the backend branch resolver.
//   bp_be_fe_cmd_type_e       - command kind sent to the frontend queue
//   bp_be_br_resolver_state_e - resolver FSM state
//   bp_be_br_cmd_s            - buffered command {cmd_type, pc, npc, taken}
// The command struct depends on the virtual address width, so it is
// declared through a macro that any module can expand at its own width.
// A default-width copy lives in the package for shared use.

`ifndef BP_BE_PKG_MACROS
`define BP_BE_PKG_MACROS

`define BP_BE_BR_CMD_WIDTH(vaddr_width_mp) (2 + 2 * (vaddr_width_mp))

`define BP_BE_DECLARE_BR_CMD_S(vaddr_width_mp) \
  typedef struct packed { \
    bp_be_fe_cmd_type_e          cmd_type; \
    logic [vaddr_width_mp-1:0]   pc; \
    logic [vaddr_width_mp-1:0]   npc; \
    logic                        taken; \
  } bp_be_br_cmd_s

`endif

package bp_be_pkg;

  localparam int vaddr_width_gp = 39;

  typedef enum logic [0:0] {
    e_fe_cmd_redirect = 1'b0,
    e_fe_cmd_attaboy  = 1'b1
  } bp_be_fe_cmd_type_e;

  typedef enum logic [0:0] {
    e_run        = 1'b0,
    e_wrong_path = 1'b1
  } bp_be_br_resolver_state_e;

  `BP_BE_DECLARE_BR_CMD_S(vaddr_width_gp);

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// bsg_fifo_1r1w_small: small one-read one-write FIFO, els_p entries.
// Ports:
//   clk_i, reset_i    - clock, synchronous active-high reset
//   v_i, ready_o      - enqueue valid / space available
//   data_i            - enqueue payload
//   v_o, data_o       - head valid / head payload
//   yumi_i            - consumer takes the head this cycle (only honored with v_o)
//   count_o           - current occupancy
// Simultaneous enqueue and dequeue keep the occupancy unchanged.

module bsg_fifo_1r1w_small #(
  parameter int width_p = 1,
  parameter int els_p   = 2
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           v_i,
  output logic                           ready_o,
  input  logic [width_p-1:0]             data_i,
  output logic                           v_o,
  output logic [width_p-1:0]             data_o,
  input  logic                           yumi_i,
  output logic [$clog2(els_p+1)-1:0]     count_o
);

  localparam int ptr_width_lp   = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int count_width_lp = $clog2(els_p + 1);

  logic [width_p-1:0]        mem_r [els_p];
  logic [ptr_width_lp-1:0]   wptr_r, rptr_r;
  logic [count_width_lp-1:0] count_r;
  logic                      enq, deq;

  assign ready_o = (count_r != count_width_lp'(els_p));
  assign v_o     = (count_r != '0);
  assign data_o  = mem_r[rptr_r];
  assign count_o = count_r;

  assign enq = v_i & ready_o;
  assign deq = yumi_i & v_o;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (enq) wptr_r <= (wptr_r == ptr_width_lp'(els_p - 1)) ? '0 : wptr_r + 1'b1;
      if (deq) rptr_r <= (rptr_r == ptr_width_lp'(els_p - 1)) ? '0 : rptr_r + 1'b1;
      case ({enq, deq})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; occupancy and pointers alone
  // decide what is valid, and the consumer gates data_o with v_o.
  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wptr_r] <= data_i;
  end

endmodule

// File: rtl/bp_be_branch_resolver.sv
// bp_be_branch_resolver: compares the resolved next PC of each branch/jump
// against the frontend prediction and returns a command to the frontend.
// Match -> attaboy (training); mismatch -> one-cycle flush plus redirect.
// Ports:
//   clk_i, reset_i                 - clock, synchronous active-high reset
//   br_v_i, pc_i, br_tgt_i,
//   npc_pred_i, taken_i            - resolved branch from the integer pipe
//   stall_o                        - issue must hold br_v_i
//   flush_o                        - squash instructions younger than the mispredict
//   fe_cmd_v_o, fe_cmd_ready_i     - command handshake toward the frontend queue
//   fe_cmd_type_o, fe_cmd_pc_o,
//   fe_cmd_npc_o, fe_cmd_taken_o   - command payload (FIFO head, zero when empty)

module bp_be_branch_resolver #(
  parameter int vaddr_width_p = 39
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     br_v_i,
  input  logic [vaddr_width_p-1:0] pc_i,
  input  logic [vaddr_width_p-1:0] br_tgt_i,
  input  logic [vaddr_width_p-1:0] npc_pred_i,
  input  logic                     taken_i,
  output logic                     stall_o,
  output logic                     flush_o,
  output logic                     fe_cmd_v_o,
  input  logic                     fe_cmd_ready_i,
  output logic                     fe_cmd_type_o,
  output logic [vaddr_width_p-1:0] fe_cmd_pc_o,
  output logic [vaddr_width_p-1:0] fe_cmd_npc_o,
  output logic                     fe_cmd_taken_o
);

  import bp_be_pkg::*;

  `BP_BE_DECLARE_BR_CMD_S(vaddr_width_p);
  localparam int cmd_width_lp = `BP_BE_BR_CMD_WIDTH(vaddr_width_p);

  bp_be_br_resolver_state_e state_r, state_n;

  // Stage R: input register
  logic                     reg_v_r;
  logic [vaddr_width_p-1:0] reg_pc_r, reg_tgt_r, reg_pred_r;
  logic                     reg_taken_r;

  // Command FIFO
  logic                     fifo_v, fifo_ready, fifo_yumi;
  logic [1:0]               fifo_count;
  logic [cmd_width_lp-1:0]  fifo_data;
  bp_be_br_cmd_s            enq_cmd, head_cmd, head_gated;

  logic mispredict, accept;

  // Stage C compare: full-width, no masking of any PC bit.
  assign mispredict = reg_v_r & (reg_tgt_r != reg_pred_r);
  assign flush_o    = mispredict;

  // Occupancy plus the in-flight compare slot; holding issue at two keeps
  // stage C from ever enqueueing into a full FIFO.
  assign stall_o = ({1'b0, fifo_count} + 3'(reg_v_r)) >= 3'd2;

  // Branches arriving in the flush cycle are already wrong-path, even though
  // the state register still reads e_run.
  assign accept = br_v_i & ~stall_o & (state_r == e_run) & ~mispredict;

  always_ff @(posedge clk_i) begin
    if (reset_i) reg_v_r <= 1'b0;
    else         reg_v_r <= accept;
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      reg_pc_r    <= pc_i;
      reg_tgt_r   <= br_tgt_i;
      reg_pred_r  <= npc_pred_i;
      reg_taken_r <= taken_i;
    end
  end

  always_comb begin
    enq_cmd.cmd_type = mispredict ? e_fe_cmd_redirect : e_fe_cmd_attaboy;
    enq_cmd.pc       = reg_pc_r;
    enq_cmd.npc      = reg_tgt_r;
    enq_cmd.taken    = reg_taken_r;
  end

  bsg_fifo_1r1w_small #(
    .width_p (cmd_width_lp),
    .els_p   (2)
  ) cmd_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (reg_v_r & fifo_ready),
    .ready_o (fifo_ready),
    .data_i  (enq_cmd),
    .v_o     (fifo_v),
    .data_o  (fifo_data),
    .yumi_i  (fifo_yumi),
    .count_o (fifo_count)
  );

  assign fifo_yumi  = fifo_v & fe_cmd_ready_i;
  assign head_cmd   = bp_be_br_cmd_s'(fifo_data);
  assign head_gated = fifo_v ? head_cmd : '0;

  assign fe_cmd_v_o     = fifo_v;
  assign fe_cmd_type_o  = head_gated.cmd_type;
  assign fe_cmd_pc_o    = head_gated.pc;
  assign fe_cmd_npc_o   = head_gated.npc;
  assign fe_cmd_taken_o = head_gated.taken;

  // FSM: leave the wrong path only once the redirect itself is handed off.
  always_ff @(posedge clk_i) begin
    if (reset_i) state_r <= e_run;
    else         state_r <= state_n;
  end

  // NOTE: state_n is given its hold value before the case so every path
  // assigns it and no latch is inferred.
  always_comb begin
    state_n = state_r;
    case (state_r)
      e_run:        if (mispredict) state_n = e_wrong_path;
      e_wrong_path: if (fifo_yumi && head_cmd.cmd_type == e_fe_cmd_redirect)
                      state_n = e_run;
      default:      state_n = e_run;
    endcase
  end

endmodule

// File: tb/tb_bp_be_branch_resolver.sv
// Self-checking bench for bp_be_branch_resolver: directed scenarios followed
// by randomized traffic, all compared against a queue-based reference model.

module tb_bp_be_branch_resolver;

  localparam int VW = 39;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          br_v_i = 1'b0;
  logic [VW-1:0] pc_i = '0, br_tgt_i = '0, npc_pred_i = '0;
  logic          taken_i = 1'b0;
  logic          stall_o, flush_o, fe_cmd_v_o;
  logic          fe_cmd_ready_i = 1'b0;
  logic          fe_cmd_type_o, fe_cmd_taken_o;
  logic [VW-1:0] fe_cmd_pc_o, fe_cmd_npc_o;

  bp_be_branch_resolver #(.vaddr_width_p(VW)) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .br_v_i         (br_v_i),
    .pc_i           (pc_i),
    .br_tgt_i       (br_tgt_i),
    .npc_pred_i     (npc_pred_i),
    .taken_i        (taken_i),
    .stall_o        (stall_o),
    .flush_o        (flush_o),
    .fe_cmd_v_o     (fe_cmd_v_o),
    .fe_cmd_ready_i (fe_cmd_ready_i),
    .fe_cmd_type_o  (fe_cmd_type_o),
    .fe_cmd_pc_o    (fe_cmd_pc_o),
    .fe_cmd_npc_o   (fe_cmd_npc_o),
    .fe_cmd_taken_o (fe_cmd_taken_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit            typ;   // 1 = attaboy, 0 = redirect
    logic [VW-1:0] pc;
    logic [VW-1:0] npc;
    bit            taken;
  } cmd_t;

  cmd_t          m_q[$];       // commands waiting for the frontend, oldest first
  bit            m_wp;         // on the wrong path after a mispredict
  bit            m_pv;         // a branch is waiting to be compared
  logic [VW-1:0] m_pc, m_tgt, m_pred;
  bit            m_taken;

  logic [VW-1:0] emitted_pc[$];
  bit            emitted_typ[$];

  function automatic bit m_stall();
    return (m_q.size() + int'(m_pv)) >= 2;
  endfunction

  function automatic bit m_flush();
    return m_pv && (m_tgt != m_pred);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_wp = 1'b0;
    m_pv = 1'b0;
  endtask

  // One clock: compare outputs against the model, drive inputs, advance model.
  task automatic step(input bit v, input logic [VW-1:0] pc, input logic [VW-1:0] tgt,
                      input logic [VW-1:0] pred, input bit taken, input bit rdy);
    cmd_t c;
    bit   deq, acc, flush_now;
    @(negedge clk);
    check("stall", stall_o, m_stall());
    check("flush", flush_o, m_flush());
    check("cmd_v", fe_cmd_v_o, m_q.size() > 0);
    if (m_q.size() > 0) begin
      check("cmd_type",  fe_cmd_type_o,  m_q[0].typ);
      check("cmd_pc",    fe_cmd_pc_o,    m_q[0].pc);
      check("cmd_npc",   fe_cmd_npc_o,   m_q[0].npc);
      check("cmd_taken", fe_cmd_taken_o, m_q[0].taken);
    end
    br_v_i = v; pc_i = pc; br_tgt_i = tgt; npc_pred_i = pred; taken_i = taken;
    fe_cmd_ready_i = rdy;
    if (fe_cmd_v_o && rdy) begin
      emitted_pc.push_back(fe_cmd_pc_o);
      emitted_typ.push_back(fe_cmd_type_o);
    end
    flush_now = m_flush();
    deq = (m_q.size() > 0) && rdy;
    acc = v && !m_stall() && !m_wp && !flush_now;
    if (!m_wp && flush_now)                  m_wp = 1'b1;
    else if (m_wp && deq && m_q[0].typ == 0) m_wp = 1'b0;
    if (deq) void'(m_q.pop_front());
    if (m_pv) begin
      c.typ = !flush_now; c.pc = m_pc; c.npc = m_tgt; c.taken = m_taken;
      m_q.push_back(c);
    end
    m_pv = acc;
    if (acc) begin m_pc = pc; m_tgt = tgt; m_pred = pred; m_taken = taken; end
    @(posedge clk);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, rdy);
  endtask

  // Present a branch and hold it while stalled, like the issue stage would.
  task automatic issue(input logic [VW-1:0] pc, input logic [VW-1:0] tgt,
                       input logic [VW-1:0] pred, input bit taken, input bit rdy);
    bit issued = 1'b0;
    for (int i = 0; i < 16 && !issued; i++) begin
      issued = !m_stall();
      step(1'b1, pc, tgt, pred, taken, rdy);
    end
    check("issue_bound", issued, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_i = 1'b1; br_v_i = 1'b0; fe_cmd_ready_i = 1'b0;
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    model_reset();
  endtask

  function automatic logic [VW-1:0] rand_addr();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[VW-1:0];
  endfunction

  initial begin
    logic [VW-1:0] a, t, p;
    bit            have;
    logic [VW-1:0] h_pc, h_tgt, h_pred;
    bit            h_taken, s;

    model_reset();
    do_reset();
    check("rst_cmd_v", fe_cmd_v_o, 0);
    check("rst_stall", stall_o, 0);
    check("rst_flush", flush_o, 0);
    check("rst_type",  fe_cmd_type_o, 0);
    check("rst_pc",    fe_cmd_pc_o, 0);
    check("rst_npc",   fe_cmd_npc_o, 0);
    check("rst_taken", fe_cmd_taken_o, 0);

    // Correct prediction
    issue(39'h80000000, 39'h80000010, 39'h80000010, 1'b1, 1'b1);
    #1 check("ok_flush_n1", flush_o, 0);
    idle(1, 1'b1);
    #1 check("ok_v_n2", fe_cmd_v_o, 1);
    check("ok_type_n2", fe_cmd_type_o, 1);
    check("ok_npc_n2",  fe_cmd_npc_o, 39'h80000010);
    idle(1, 1'b1);
    #1 check("ok_v_n3", fe_cmd_v_o, 0);

    // Mispredict with the frontend not ready
    issue(39'h80000020, 39'h80000100, 39'h80000024, 1'b1, 1'b0);
    #1 check("mp_flush_n1", flush_o, 1);
    step(1'b1, 39'h200, 39'h204, 39'h204, 1'b0, 1'b0);   // flush-cycle branch is dropped
    #1 check("mp_flush_n2", flush_o, 0);
    check("mp_v",    fe_cmd_v_o, 1);
    check("mp_type", fe_cmd_type_o, 0);
    check("mp_pc",   fe_cmd_pc_o, 39'h80000020);
    check("mp_npc",  fe_cmd_npc_o, 39'h80000100);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 39'h300 + VW'(4 * i), 39'h400, 39'h500, 1'b1, 1'b0);
      #1 check("mp_hold_pc", fe_cmd_pc_o, 39'h80000020);
      check("mp_hold_flush", flush_o, 0);
    end
    idle(1, 1'b1);
    #1 check("mp_drained", fe_cmd_v_o, 0);
    issue(39'h700, 39'h704, 39'h704, 1'b0, 1'b0);
    idle(1, 1'b0);
    #1 check("mp_rerun_v", fe_cmd_v_o, 1);
    check("mp_rerun_pc", fe_cmd_pc_o, 39'h700);
    idle(1, 1'b1);

    // Backpressure: three matches, frontend stalled
    emitted_pc.delete(); emitted_typ.delete();
    issue(39'h300, 39'h304, 39'h304, 1'b0, 1'b0);
    issue(39'h304, 39'h308, 39'h308, 1'b0, 1'b0);
    step(1'b1, 39'h308, 39'h30c, 39'h30c, 1'b0, 1'b0);
    #1 check("bp_stall_a", stall_o, 1);
    step(1'b1, 39'h308, 39'h30c, 39'h30c, 1'b0, 1'b0);
    #1 check("bp_stall_b", stall_o, 1);
    issue(39'h308, 39'h30c, 39'h30c, 1'b0, 1'b1);
    idle(6, 1'b1);
    check("bp_count", emitted_pc.size(), 3);
    if (emitted_pc.size() == 3) begin
      check("bp_ord0", emitted_pc[0], 39'h300);
      check("bp_ord1", emitted_pc[1], 39'h304);
      check("bp_ord2", emitted_pc[2], 39'h308);
    end

    // Ordering: older attaboy drains ahead of the redirect
    emitted_pc.delete(); emitted_typ.delete();
    issue(39'h100, 39'h104, 39'h104, 1'b0, 1'b0);
    issue(39'h104, 39'h200, 39'h108, 1'b1, 1'b0);
    idle(2, 1'b0);
    idle(4, 1'b1);
    check("ord_count", emitted_pc.size(), 2);
    if (emitted_pc.size() == 2) begin
      check("ord_pc0",  emitted_pc[0], 39'h100);
      check("ord_typ0", emitted_typ[0], 1);
      check("ord_pc1",  emitted_pc[1], 39'h104);
      check("ord_typ1", emitted_typ[1], 0);
    end

    // Top-bit-only difference must mispredict
    t = 39'h00_4000_1000;
    p = t ^ (39'h1 << (VW - 1));
    issue(39'h00_4000_0ffc, t, p, 1'b1, 1'b1);
    #1 check("topbit_flush", flush_o, 1);
    idle(4, 1'b1);

    // Reset while on the wrong path with two queued commands
    issue(39'h500, 39'h504, 39'h504, 1'b0, 1'b0);
    issue(39'h504, 39'h900, 39'h508, 1'b1, 1'b0);
    idle(2, 1'b0);
    #1 check("rst_mid_v_before", fe_cmd_v_o, 1);
    do_reset();
    check("rst_mid_v",     fe_cmd_v_o, 0);
    check("rst_mid_stall", stall_o, 0);
    check("rst_mid_flush", flush_o, 0);
    issue(39'h600, 39'h604, 39'h604, 1'b1, 1'b1);
    idle(1, 1'b1);
    #1 check("rst_mid_new_v",  fe_cmd_v_o, 1);
    check("rst_mid_new_pc", fe_cmd_pc_o, 39'h600);
    check("rst_mid_new_ty", fe_cmd_type_o, 1);
    idle(2, 1'b1);

    // Randomized traffic, issue holds stalled branches
    have = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(499) == 0) begin
        do_reset();
        have = 1'b0;
      end
      if (!have && $urandom_range(1)) begin
        have  = 1'b1;
        h_pc  = rand_addr();
        h_tgt = rand_addr();
        case ($urandom_range(9))
          0, 1:    h_pred = rand_addr();
          2:       h_pred = h_tgt ^ (39'h1 << (VW - 1));
          default: h_pred = h_tgt;
        endcase
        h_taken = 1'($urandom);
      end
      s = m_stall();
      a = have ? h_pc : '0;
      step(have, a, h_tgt, h_pred, h_taken, $urandom_range(2) != 0);
      if (have && !s) have = 1'b0;
    end
    idle(6, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
